// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// sequencer state encoding and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    MEM   = 2'd3
  } state_t;

  localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flushes and
// memory-busy freezes for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BR_PENALTY  = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_Rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             hazard_detected,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] BR_RELOAD = 3'(BR_PENALTY - 1);
  localparam logic [7:0] TO_LIMIT  = 8'(MEM_TIMEOUT);

  state_t     state, state_n;
  logic [2:0] fcnt, fcnt_n;
  logic [7:0] wcnt, wcnt_n;
  logic       load_use;
  logic       br_ev;

  assign load_use = id_ex_MemRead && (id_ex_Rd != X0) &&
                    ((id_ex_Rd == if_id_rs1) ||
                     (if_id_uses_rs2 && id_ex_Rd == if_id_rs2));

  always_comb begin
    hazard_detected = 1'b0;
    PCWrite         = 1'b1;
    IF_ID_Write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    pipe_freeze     = 1'b0;
    state_n         = state;
    fcnt_n          = fcnt;
    wcnt_n          = '0;
    br_ev           = 1'b0;
    if (reset) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_n     = RUN;
      fcnt_n      = '0;
    end else if (state == MEM) begin
      // EX is frozen here, so a branch_taken pulse is not a real event
      if (mem_busy) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        pipe_freeze = 1'b1;
        wcnt_n      = (wcnt == TO_LIMIT) ? wcnt : wcnt + 8'd1;
      end else begin
        state_n = (fcnt != '0) ? FLUSH : RUN;
      end
    end else begin
      priority case (1'b1)
        branch_taken: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          br_ev       = 1'b1;
          fcnt_n      = BR_RELOAD;
          state_n     = (BR_PENALTY > 1) ? FLUSH : RUN;
        end
        mem_busy: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          pipe_freeze = 1'b1;
          wcnt_n      = wcnt + 8'd1;
          state_n     = MEM;
        end
        (state == FLUSH): begin
          if_id_flush = 1'b1;
          fcnt_n      = fcnt - 3'd1;
          if (fcnt == 3'd1)
            state_n = RUN;
        end
        (state == RUN && load_use): begin
          hazard_detected = 1'b1;
          PCWrite         = 1'b0;
          IF_ID_Write     = 1'b0;
          state_n         = STALL;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      fcnt        <= '0;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      wcnt  <= wcnt_n;
      if (wcnt_n == TO_LIMIT)
        mem_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!PCWrite),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br_ev),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int BRP  = 2;
  localparam int MT   = 10;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    if_id_rs1, if_id_rs2, id_ex_Rd;
  logic          if_id_uses_rs2, id_ex_MemRead;
  logic          branch_taken, mem_busy;
  logic          hazard_detected, PCWrite, IF_ID_Write;
  logic          if_id_flush, id_ex_flush, pipe_freeze, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  int fl = 0, wt = 0, sc = 0, fc = 0;
  bit st = 0, mm = 0, to = 0;

  // last sampled combinational outputs
  bit s_pcw, s_ifw, s_hz, s_f1, s_f2, s_fz;

  pipeline_hazard_ctrl #(
    .BR_PENALTY (BRP),
    .MEM_TIMEOUT(MT),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .if_id_uses_rs2 (if_id_uses_rs2),
    .id_ex_MemRead  (id_ex_MemRead),
    .id_ex_Rd       (id_ex_Rd),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .hazard_detected(hazard_detected),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .pipe_freeze    (pipe_freeze),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit br, input bit bz,
                       input bit mr, input int rd, input int r1,
                       input int r2, input bit u2);
    bit lu;
    bit pcw, ifw, hz, f1, f2, fz;
    reset          = r;
    branch_taken   = br;
    mem_busy       = bz;
    id_ex_MemRead  = mr;
    id_ex_Rd       = 5'(rd);
    if_id_rs1      = 5'(r1);
    if_id_rs2      = 5'(r2);
    if_id_uses_rs2 = u2;
    #1;
    lu = mr && rd != 0 && (rd == r1 || (u2 && rd == r2));
    pcw = 1; ifw = 1; hz = 0; f1 = 0; f2 = 0; fz = 0;
    if (r) begin
      pcw = 0; ifw = 0; f1 = 1; f2 = 1;
    end else if (mm) begin
      if (bz) begin pcw = 0; ifw = 0; fz = 1; end
    end else if (br) begin
      f1 = 1; f2 = 1;
    end else if (bz) begin
      pcw = 0; ifw = 0; fz = 1;
    end else if (fl > 0) begin
      f1 = 1;
    end else if (!st && lu) begin
      hz = 1; pcw = 0; ifw = 0;
    end
    chk("PCWrite", int'(PCWrite), int'(pcw));
    chk("IF_ID_Write", int'(IF_ID_Write), int'(ifw));
    chk("hazard_detected", int'(hazard_detected), int'(hz));
    chk("if_id_flush", int'(if_id_flush), int'(f1));
    chk("id_ex_flush", int'(id_ex_flush), int'(f2));
    chk("pipe_freeze", int'(pipe_freeze), int'(fz));
    chk("stall_cnt", int'(stall_cnt), sc);
    chk("flush_cnt", int'(flush_cnt), fc);
    chk("mem_timeout", int'(mem_timeout), int'(to));
    s_pcw = PCWrite; s_ifw = IF_ID_Write; s_hz = hazard_detected;
    s_f1 = if_id_flush; s_f2 = id_ex_flush; s_fz = pipe_freeze;
    if (r) begin
      fl = 0; wt = 0; sc = 0; fc = 0; st = 0; mm = 0; to = 0;
    end else begin
      if (!pcw && sc < CMAX) sc++;
      if (mm) begin
        if (bz) begin
          wt++;
          if (wt >= MT) to = 1;
        end else begin
          mm = 0; wt = 0;
        end
        st = 0;
      end else if (br) begin
        if (fc < CMAX) fc++;
        fl = BRP - 1; st = 0;
      end else if (bz) begin
        mm = 1; wt = 1; st = 0;
        if (wt >= MT) to = 1;
      end else if (fl > 0) begin
        fl--; st = 0;
      end else begin
        st = !st && lu;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int hold;
    bit bz, br, rr;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pcw_lit", int'(s_pcw), 0);
    chk("rst_flush_lit", int'(s_f1 & s_f2), 1);
    chk("rst_freeze_lit", int'(s_fz), 0);
    chk("rst_cnt_lit", int'(stall_cnt) + int'(flush_cnt), 0);

    // load-use on rs1
    cycle(0, 0, 0, 1, 5, 5, 0, 0);
    chk("lu_hz_lit", int'(s_hz), 1);
    chk("lu_pcw_lit", int'(s_pcw), 0);
    cycle(0, 0, 0, 1, 5, 5, 0, 0);
    chk("lu_masked_lit", int'(s_hz), 0);
    chk("lu_stall_cnt_lit", int'(stall_cnt), 1);

    // x0 and rs2 gating
    cycle(0, 0, 0, 1, 0, 0, 0, 1);
    chk("x0_lit", int'(s_hz), 0);
    cycle(0, 0, 0, 1, 7, 1, 7, 0);
    chk("rs2_unused_lit", int'(s_hz), 0);
    cycle(0, 0, 0, 1, 7, 1, 7, 1);
    chk("rs2_used_lit", int'(s_hz), 1);
    idle(1);

    // branch with simultaneous load-use
    cycle(0, 1, 0, 1, 5, 5, 0, 0);
    chk("br_c0_lit", int'(s_f1 & s_f2 & s_pcw & !s_hz), 1);
    cycle(0, 0, 0, 1, 5, 5, 0, 0);
    chk("br_c1_f1_lit", int'(s_f1), 1);
    chk("br_c1_f2_lit", int'(s_f2 | s_hz), 0);
    idle(1);
    chk("br_c2_lit", int'(s_f1 | s_f2), 0);
    chk("br_cnt_lit", int'(flush_cnt), 1);

    // memory busy during flush, then residual flush
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 0, 0);
      chk("mem_fz_lit", int'(s_fz & !s_pcw), 1);
    end
    idle(1);
    idle(1);
    chk("resid_flush_lit", int'(s_f1 & !s_f2 & s_pcw), 1);
    idle(1);
    chk("stall5_lit", int'(stall_cnt), 5);

    // timeout and saturation
    for (int i = 0; i < MT; i++) cycle(0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("timeout_lit", int'(mem_timeout), 1);
    chk("sat15_lit", int'(stall_cnt), 15);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    chk("sat_hold_lit", int'(stall_cnt), 15);
    chk("timeout_sticky_lit", int'(mem_timeout), 1);

    // reset while in MEM
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0, 0);
    chk("rst_mem_lit", int'(s_f1 & !s_fz), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_run_lit", int'(s_pcw & !s_f1 & !s_fz), 1);
    chk("post_rst_to_lit", int'(mem_timeout), 0);
    chk("post_rst_cnt_lit", int'(stall_cnt) + int'(flush_cnt), 0);

    // randomized traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold > 0) begin
        bz = 1; hold--;
      end else if ($urandom_range(0, 99) < 8) begin
        hold = $urandom_range(0, 13); bz = 1;
      end else begin
        bz = 0;
      end
      br = ($urandom_range(0, 99) < 10);
      rr = ($urandom_range(0, 199) == 0);
      cycle(rr, br, bz, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
